ins_loader: RTL and testbench
=============================

INS_LOADER -- requirements
Module: ins_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, giving the maximum program length in 32-bit words.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port START, input, 1, a one-cycle request to begin a load.
REQ-005 SHALL have port BYTE_IN, input, 8, the incoming stream byte.
REQ-006 SHALL have port BYTE_VALID, input, 1, meaning BYTE_IN is valid.
REQ-007 SHALL have port BYTE_READY, output, 1, meaning the loader accepts BYTE_IN this cycle.
REQ-008 SHALL have port W_Ins, output, 32, the assembled instruction word for the core.
REQ-009 SHALL have port WE, output, 1, the instruction-memory write strobe to the core.
REQ-010 SHALL have port W_Addr, output, 16, the index of the word being written.
REQ-011 SHALL have port CORE_RST, output, 1, an active-high hold applied to the core's reset.
REQ-012 SHALL have port DONE, output, 1, meaning the load completed successfully.
REQ-013 SHALL have port ERR, output, 1, meaning the load was aborted.

Function
REQ-014 SHALL use the states IDLE, HDR_HI, HDR_LO, DATA, WRITE, CSUM, FIN and FAIL.
REQ-015 SHALL accept a byte only on a cycle where BYTE_VALID and BYTE_READY are both 1.
REQ-016 SHALL drive BYTE_READY=1 only in HDR_HI, HDR_LO, DATA and CSUM.
REQ-017 SHALL, on START in IDLE, FIN or FAIL, clear the counters, checksum, DONE and ERR, and go to HDR_HI; START in any other state is ignored.
REQ-018 SHALL form the word count N from the HDR_HI byte (high) and the HDR_LO byte (low).
REQ-019 SHALL go to FAIL after HDR_LO if N=0 or N>MAX_WORDS, and to DATA otherwise.
REQ-020 SHALL, in DATA, assemble 4 accepted bytes big-endian, first byte into bits [31:24]; the 4th byte moves the state to WRITE.
REQ-021 SHALL, in WRITE, hold for exactly one cycle with WE=1, W_Ins=the assembled word and W_Addr=the word index, then increment the word index.
REQ-022 SHALL drive WE=0 in every state other than WRITE and SHALL keep W_Ins stable outside WRITE.
REQ-023 SHALL, after WRITE, go to DATA if the word index is below N, otherwise to CSUM or FIN depending on configuration.
REQ-024 SHALL drive CORE_RST=1 in every state except FIN, where it is 0.
REQ-025 SHALL drive DONE=1 only in FIN and ERR=1 only in FAIL; FIN and FAIL are held until START.
REQ-026 SHALL let a BYTE_VALID gap of any length stall the loader with no state change.
REQ-027 SHALL wrap W_Addr from 0xFFFF to 0 naturally; with N≤MAX_WORDS it never reaches that point.

Reset
REQ-028 SHALL, while RST=0, immediately force state=IDLE, CORE_RST=1, WE=0, BYTE_READY=0, DONE=0, ERR=0, W_Ins=0, W_Addr=0 and clear the counters and checksum.
REQ-029 SHALL, on reset during any state including WRITE, abandon the partial load and perform no further WE pulse.

Configuration
REQ-030 SHALL be controlled by macro INS_LOADER_CHECKSUM_EN.
REQ-031 SHALL, with the macro defined, maintain a running XOR of all header and payload bytes, read one trailing byte in CSUM, and go to FIN if the byte equals the XOR and to FAIL otherwise.
REQ-032 SHALL, with the macro undefined, contain no CSUM state and no checksum logic, and go from the last WRITE directly to FIN.

Verification
REQ-033 SHALL verify (macro off) START, then bytes 00 01 20 08 00 05 -> one WE pulse with W_Ins=0x20080005 and W_Addr=0, then DONE=1 and CORE_RST=0.
REQ-034 SHALL verify header 00 00 -> ERR=1, CORE_RST=1 and no WE pulse; header giving N=MAX_WORDS+1 -> ERR=1.
REQ-035 SHALL verify N=2 with random BYTE_VALID gaps -> WE pulses at W_Addr=0 and 1 with the correct words and BYTE_READY=0 during each WRITE.
REQ-036 SHALL verify (macro on) a correct XOR trailer -> DONE=1 and a corrupted trailer -> ERR=1 with CORE_RST still 1.
REQ-037 SHALL verify that RST=0 asserted mid-DATA after 2 bytes -> all outputs at reset values; a new START then loads correctly from W_Addr=0.

Source files
------------

// File: rtl/ins_loader.sv
// ins_loader: streams a length-prefixed program into instruction memory while holding the core in reset.
// Optional trailing XOR checksum of header and payload enabled by INS_LOADER_CHECKSUM_EN.
module ins_loader #(
   parameter int MAX_WORDS = 256
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [7:0]  BYTE_IN,
   input  logic        BYTE_VALID,
   output logic        BYTE_READY,
   output logic [31:0] W_Ins,
   output logic        WE,
   output logic [15:0] W_Addr,
   output logic        CORE_RST,
   output logic        DONE,
   output logic        ERR
);
`ifdef INS_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, WRITE, CSUM, FIN, FAIL} state_t;
`else
   typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, WRITE, FIN, FAIL} state_t;
`endif
   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);
   state_t      state_q, state_d;
   logic [15:0] n_q, n_d, addr_q, addr_d, n_hdr;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [23:0] sh_q, sh_d;
   logic [31:0] ins_q, ins_d;
   logic        acc;
`ifdef INS_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
   assign BYTE_READY = state_q inside {HDR_HI, HDR_LO, DATA, CSUM};
`else
   assign BYTE_READY = state_q inside {HDR_HI, HDR_LO, DATA};
`endif
   assign WE       = state_q == WRITE;
   assign W_Ins    = ins_q;
   assign W_Addr   = addr_q;
   assign CORE_RST = state_q != FIN;
   assign DONE     = state_q == FIN;
   assign ERR      = state_q == FAIL;
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      addr_d  = addr_q;
      bcnt_d  = bcnt_q;
      sh_d    = sh_q;
      ins_d   = ins_q;
      n_hdr   = {n_q[15:8], BYTE_IN};
      acc     = BYTE_VALID && BYTE_READY;
`ifdef INS_LOADER_CHECKSUM_EN
      csum_d  = (acc && state_q != CSUM) ? csum_q ^ BYTE_IN : csum_q;
`endif
      case (state_q)
         IDLE, FIN, FAIL: if (START) begin
            state_d = HDR_HI;
            n_d     = '0;
            addr_d  = '0;
            bcnt_d  = '0;
`ifdef INS_LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
         end
         HDR_HI: if (acc) begin
            n_d     = {BYTE_IN, 8'h00};
            state_d = HDR_LO;
         end
         HDR_LO: if (acc) begin
            n_d     = n_hdr;
            state_d = (n_hdr == 16'd0 || {1'b0, n_hdr} > MAX_N) ? FAIL : DATA;
         end
         DATA: if (acc) begin
            sh_d   = {sh_q[15:0], BYTE_IN};
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
               ins_d   = {sh_q, BYTE_IN};
               state_d = WRITE;
            end
         end
         WRITE: begin
            addr_d = addr_q + 16'd1;
`ifdef INS_LOADER_CHECKSUM_EN
            state_d = (addr_d < n_q) ? DATA : CSUM;
`else
            state_d = (addr_d < n_q) ? DATA : FIN;
`endif
         end
`ifdef INS_LOADER_CHECKSUM_EN
         CSUM: if (acc) state_d = (BYTE_IN == csum_q) ? FIN : FAIL;
`endif
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         n_q     <= '0;
         addr_q  <= '0;
         bcnt_q  <= '0;
         sh_q    <= '0;
         ins_q   <= '0;
`ifdef INS_LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         addr_q  <= addr_d;
         bcnt_q  <= bcnt_d;
         sh_q    <= sh_d;
         ins_q   <= ins_d;
`ifdef INS_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end
endmodule

// File: tb/tb_ins_loader.sv
// tb_ins_loader: directed checks of ins_loader loads, header errors, gaps, checksum and mid-load reset.
module tb_ins_loader;
   logic        CLK = 1'b0, RST = 1'b0, START = 1'b0, BYTE_VALID = 1'b0;
   logic [7:0]  BYTE_IN = 8'h00;
   logic        BYTE_READY, WE, CORE_RST, DONE, ERR;
   logic [31:0] W_Ins;
   logic [15:0] W_Addr;
   int          tests = 0, fails = 0, ready_bad = 0;
   logic [31:0] pay[$];
   logic [15:0] we_addr[$];
   logic [31:0] we_ins[$];

   ins_loader #(.MAX_WORDS(256)) dut (
      .CLK(CLK), .RST(RST), .START(START), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
      .BYTE_READY(BYTE_READY), .W_Ins(W_Ins), .WE(WE), .W_Addr(W_Addr),
      .CORE_RST(CORE_RST), .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   // Log every write cycle; the loader must not take bytes while writing.
   always @(negedge CLK) if (WE) begin
      we_addr.push_back(W_Addr);
      we_ins.push_back(W_Ins);
      if (BYTE_READY) ready_bad++;
   end

   task automatic do_start;
      @(negedge CLK); START = 1'b1;
      @(negedge CLK); START = 1'b0;
      we_addr.delete(); we_ins.delete(); ready_bad = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t = 0;
      repeat (gap) @(negedge CLK);
      BYTE_IN = b; BYTE_VALID = 1'b1;
      while (!BYTE_READY && t < 40) begin @(negedge CLK); t++; end
      if (!BYTE_READY) begin
         tests++; fails++;
         $display("FAIL send_byte: BYTE_READY got 0 required 1 for byte %h", b);
      end
      @(posedge CLK); #1 BYTE_VALID = 1'b0;
   endtask

   task automatic send_load(input logic [15:0] n, input int maxgap, input bit corrupt);
      logic [7:0]  cs;
      logic [31:0] w;
      cs = n[15:8] ^ n[7:0];
      send_byte(n[15:8], 0);
      send_byte(n[7:0], 0);
      foreach (pay[i]) begin
         w = pay[i];
         for (int k = 3; k >= 0; k--) begin
            send_byte(w[8*k +: 8], $urandom_range(0, maxgap));
            cs ^= w[8*k +: 8];
         end
      end
      cs = corrupt ? ~cs : cs;
`ifdef INS_LOADER_CHECKSUM_EN
      send_byte(cs, 0);
`endif
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge CLK);
      tests++; if (CORE_RST !== 1'b1) begin fails++; $display("FAIL rst_core_rst got %b req 1", CORE_RST); end
      tests++; if (WE !== 1'b0) begin fails++; $display("FAIL rst_we got %b req 0", WE); end
      tests++; if (BYTE_READY !== 1'b0) begin fails++; $display("FAIL rst_ready got %b req 0", BYTE_READY); end
      tests++; if ({DONE, ERR} !== 2'b00) begin fails++; $display("FAIL rst_done_err got %b req 00", {DONE, ERR}); end
      tests++; if (W_Ins !== 32'h0 || W_Addr !== 16'h0) begin fails++; $display("FAIL rst_ins_addr got %h/%h req 0/0", W_Ins, W_Addr); end
      RST = 1'b1;
      @(negedge CLK);
      tests++; if (BYTE_READY !== 1'b0 || DONE !== 1'b0) begin fails++; $display("FAIL idle_outputs got ready=%b done=%b req 0/0", BYTE_READY, DONE); end
   endtask

   task automatic test_single_word;
      do_start();
      pay = '{32'h20080005};
      send_load(16'd1, 0, 1'b0);
      tests++; if (we_addr.size() !== 1) begin fails++; $display("FAIL single_we_count got %0d req 1", we_addr.size()); end
      else begin
         tests++; if (we_addr[0] !== 16'd0) begin fails++; $display("FAIL single_addr got %h req 0000", we_addr[0]); end
         tests++; if (we_ins[0] !== 32'h20080005) begin fails++; $display("FAIL single_ins got %h req 20080005", we_ins[0]); end
      end
      tests++; if (DONE !== 1'b1 || ERR !== 1'b0) begin fails++; $display("FAIL single_done got done=%b err=%b req 1/0", DONE, ERR); end
      tests++; if (CORE_RST !== 1'b0) begin fails++; $display("FAIL single_core_rst got %b req 0", CORE_RST); end
      tests++; if (W_Ins !== 32'h20080005) begin fails++; $display("FAIL single_ins_hold got %h req 20080005", W_Ins); end
   endtask

   task automatic test_hdr_errors;
      do_start();
      send_byte(8'h00, 0); send_byte(8'h00, 0);
      repeat (3) @(negedge CLK);
      tests++; if (ERR !== 1'b1 || DONE !== 1'b0) begin fails++; $display("FAIL hdr_zero_err got err=%b done=%b req 1/0", ERR, DONE); end
      tests++; if (CORE_RST !== 1'b1) begin fails++; $display("FAIL hdr_zero_core_rst got %b req 1", CORE_RST); end
      tests++; if (we_addr.size() !== 0) begin fails++; $display("FAIL hdr_zero_we got %0d pulses req 0", we_addr.size()); end
      tests++; if (BYTE_READY !== 1'b0) begin fails++; $display("FAIL hdr_zero_ready got %b req 0", BYTE_READY); end
      do_start();
      tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL restart_err_clear got %b req 0", ERR); end
      send_byte(8'h01, 0); send_byte(8'h01, 0);
      repeat (3) @(negedge CLK);
      tests++; if (ERR !== 1'b1 || we_addr.size() !== 0) begin fails++; $display("FAIL hdr_257 got err=%b we=%0d req 1/0", ERR, we_addr.size()); end
   endtask

   task automatic test_max_words;
      do_start();
      pay.delete();
      for (int i = 0; i < 256; i++) pay.push_back({16'hA5C3, 16'(i)});
      send_load(16'd256, 0, 1'b0);
      tests++; if (we_addr.size() !== 256) begin fails++; $display("FAIL max_we_count got %0d req 256", we_addr.size()); end
      else begin
         tests++; if (we_addr[255] !== 16'd255 || we_ins[255] !== 32'hA5C300FF) begin fails++; $display("FAIL max_last got %h/%h req 00ff/a5c300ff", we_addr[255], we_ins[255]); end
      end
      tests++; if (DONE !== 1'b1) begin fails++; $display("FAIL max_done got %b req 1", DONE); end
   endtask

   task automatic test_gaps;
      do_start();
      pay = '{32'hDEADBEEF, 32'h01234567};
      send_load(16'd2, 3, 1'b0);
      tests++; if (we_addr.size() !== 2) begin fails++; $display("FAIL gaps_we_count got %0d req 2", we_addr.size()); end
      else begin
         tests++; if (we_addr[0] !== 16'd0 || we_ins[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL gaps_w0 got %h/%h req 0000/deadbeef", we_addr[0], we_ins[0]); end
         tests++; if (we_addr[1] !== 16'd1 || we_ins[1] !== 32'h01234567) begin fails++; $display("FAIL gaps_w1 got %h/%h req 0001/01234567", we_addr[1], we_ins[1]); end
      end
      tests++; if (ready_bad !== 0) begin fails++; $display("FAIL gaps_ready_in_write got %0d req 0", ready_bad); end
      tests++; if (DONE !== 1'b1) begin fails++; $display("FAIL gaps_done got %b req 1", DONE); end
   endtask

`ifdef INS_LOADER_CHECKSUM_EN
   task automatic test_checksum;
      do_start();
      pay = '{32'h11223344, 32'hCAFEF00D};
      send_load(16'd2, 1, 1'b0);
      tests++; if (DONE !== 1'b1 || ERR !== 1'b0) begin fails++; $display("FAIL csum_good got done=%b err=%b req 1/0", DONE, ERR); end
      do_start();
      send_load(16'd2, 1, 1'b1);
      tests++; if (ERR !== 1'b1 || DONE !== 1'b0) begin fails++; $display("FAIL csum_bad got err=%b done=%b req 1/0", ERR, DONE); end
      tests++; if (CORE_RST !== 1'b1) begin fails++; $display("FAIL csum_bad_core_rst got %b req 1", CORE_RST); end
   endtask
`endif

   task automatic test_reset_mid;
      do_start();
      send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
      @(negedge CLK); RST = 1'b0; #1;
      tests++; if (W_Ins !== 32'h0 || W_Addr !== 16'h0) begin fails++; $display("FAIL mid_rst_ins_addr got %h/%h req 0/0", W_Ins, W_Addr); end
      tests++; if ({CORE_RST, WE, BYTE_READY, DONE, ERR} !== 5'b10000) begin fails++; $display("FAIL mid_rst_ctrl got %b req 10000", {CORE_RST, WE, BYTE_READY, DONE, ERR}); end
      @(negedge CLK); RST = 1'b1;
      do_start();
      pay = '{32'h20080005};
      send_load(16'd1, 0, 1'b0);
      tests++; if (we_addr.size() !== 1) begin fails++; $display("FAIL mid_reload_count got %0d req 1", we_addr.size()); end
      else begin
         tests++; if (we_addr[0] !== 16'd0 || we_ins[0] !== 32'h20080005) begin fails++; $display("FAIL mid_reload_word got %h/%h req 0000/20080005", we_addr[0], we_ins[0]); end
      end
      tests++; if (DONE !== 1'b1) begin fails++; $display("FAIL mid_reload_done got %b req 1", DONE); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_hdr_errors();
      test_max_words();
      test_gaps();
`ifdef INS_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
